// File: rtl/uart_rx_if.sv
// UART receiver bus: oversample tick and serial line in, received byte and
// status strobes out. The receiver sits on the slave side.
`timescale 1ns/1ps

interface uart_rx_if;
    logic       bclk;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    modport master (
        output bclk,
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );

    modport slave (
        input  bclk,
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with an optional parity bit.
// The start bit is confirmed mid-bit. Data, parity and stop are then sampled
// every 16 ticks. Frame results are presented as one-clk registered strobes.
`timescale 1ns/1ps

module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam int         SHIFT_AMT = 8 - DATA_BITS;
    localparam logic       HAS_PAR   = (PARITY_EN != 0);
    localparam logic       ODD_PAR   = (PARITY_ODD != 0);

    // Error flag: the data bits XORed with the received parity bit and the odd
    // selector give 1 exactly when the frame's parity is wrong.
    function automatic logic f_parity_err(input logic [7:0] data, input logic par_bit);
        return (^data) ^ par_bit ^ ODD_PAR;
    endfunction

    state_t     r_state;
    state_t     w_state_next;
    logic       r_sync1;
    logic       r_rx_s;
    logic       r_rx_d;
    logic [3:0] r_tick;
    logic [2:0] r_bitcnt;
    logic [7:0] r_shift;
    logic       r_par_bit;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_frame_err;
    logic       r_parity_err;
    logic       r_busy;

    logic       w_fall;
    logic       w_tick_mid;
    logic       w_tick_last;
    logic       w_last_bit;
    logic       w_tick_clr;
    logic       w_tick_inc;
    logic       w_bit_clr;
    logic       w_bit_inc;
    logic       w_shift_en;
    logic       w_par_sample;
    logic       w_stop_sample;
    logic [7:0] w_aligned;

    assign w_fall      = r_rx_d & ~r_rx_s;
    assign w_tick_mid  = (r_tick == 4'd7);
    assign w_tick_last = (r_tick == 4'd15);
    assign w_last_bit  = (r_bitcnt == LAST_BIT);
    // The shift register fills from the MSB, so the first bit received ends up
    // in bit 0 once the word is shifted down by the unused width.
    assign w_aligned   = r_shift >> SHIFT_AMT;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. Only IDLE reacts on non-tick cycles.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_next = S_START;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_START: begin
                if (bus.bclk && w_tick_mid) begin
                    if (r_rx_s) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end else begin
                    w_state_next = S_START;
                end
            end
            S_DATA: begin
                if (bus.bclk && w_tick_last && w_last_bit) begin
                    if (HAS_PAR) begin
                        w_state_next = S_PARITY;
                    end else begin
                        w_state_next = S_STOP;
                    end
                end else begin
                    w_state_next = S_DATA;
                end
            end
            S_PARITY: begin
                if (bus.bclk && w_tick_last) begin
                    w_state_next = S_STOP;
                end else begin
                    w_state_next = S_PARITY;
                end
            end
            S_STOP: begin
                if (bus.bclk && w_tick_last) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_STOP;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Per-state control strobes for the counters, shifter and frame result.
    always_comb begin
        w_tick_clr    = 1'b0;
        w_tick_inc    = 1'b0;
        w_bit_clr     = 1'b0;
        w_bit_inc     = 1'b0;
        w_shift_en    = 1'b0;
        w_par_sample  = 1'b0;
        w_stop_sample = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tick_clr = 1'b1;
                w_bit_clr  = 1'b1;
            end
            S_START: begin
                if (bus.bclk) begin
                    if (w_tick_mid) begin
                        w_tick_clr = 1'b1;
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end else begin
                    w_tick_inc = 1'b0;
                end
            end
            S_DATA: begin
                if (bus.bclk) begin
                    w_tick_inc = 1'b1;
                    if (w_tick_last) begin
                        w_shift_en = 1'b1;
                        if (w_last_bit) begin
                            w_bit_clr = 1'b1;
                        end else begin
                            w_bit_inc = 1'b1;
                        end
                    end else begin
                        w_shift_en = 1'b0;
                    end
                end else begin
                    w_tick_inc = 1'b0;
                end
            end
            S_PARITY: begin
                if (bus.bclk) begin
                    w_tick_inc   = 1'b1;
                    w_par_sample = w_tick_last;
                end else begin
                    w_tick_inc = 1'b0;
                end
            end
            S_STOP: begin
                if (bus.bclk) begin
                    w_tick_inc    = 1'b1;
                    w_stop_sample = w_tick_last;
                end else begin
                    w_tick_inc = 1'b0;
                end
            end
            default: begin
                w_tick_clr = 1'b1;
                w_bit_clr  = 1'b1;
            end
        endcase
    end

    // Tick/bit counters, data shifter and captured parity bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick    <= 4'd0;
            r_bitcnt  <= 3'd0;
            r_shift   <= 8'd0;
            r_par_bit <= 1'b0;
        end else begin
            if (w_tick_clr) begin
                r_tick <= 4'd0;
            end else if (w_tick_inc) begin
                r_tick <= r_tick + 4'd1;
            end else begin
                r_tick <= r_tick;
            end

            if (w_bit_clr) begin
                r_bitcnt <= 3'd0;
            end else if (w_bit_inc) begin
                r_bitcnt <= r_bitcnt + 3'd1;
            end else begin
                r_bitcnt <= r_bitcnt;
            end

            if (w_shift_en) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end else begin
                r_shift <= r_shift;
            end

            if (w_par_sample) begin
                r_par_bit <= r_rx_s;
            end else begin
                r_par_bit <= r_par_bit;
            end
        end
    end

    // Registered outputs. rx_data only moves on a good frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_data    <= 8'd0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rx_valid   <= w_stop_sample & r_rx_s;
            r_frame_err  <= w_stop_sample & ~r_rx_s;
            r_parity_err <= HAS_PAR & w_stop_sample & f_parity_err(w_aligned, r_par_bit);
            r_busy       <= (w_state_next != S_IDLE);
            if (w_stop_sample && r_rx_s) begin
                r_rx_data <= w_aligned;
            end else begin
                r_rx_data <= r_rx_data;
            end
        end
    end

    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.parity_err = r_parity_err;
    assign bus.busy       = r_busy;

endmodule
